airlock_ctrl: RTL

- Sequencer for the airlock chamber: arbitrates inbound (arrive) and outbound (depart) passage requests.
- Drives the inner and outer door commands and the pressurize/evacuate pump commands.
- Times the pressurize and depressurize phases with internal countdowns.
- Sits above the door actuators and the pump driver; a door is never opened unless the chamber pressure matches that side.

---
 rtl/airlock_ctrl_if.sv | 32 +++
 rtl/airlock_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/airlock_ctrl_if.sv
// Airlock controller bus: vessel requests, chamber sensor, door/pump commands and status.
// master = the side that raises requests and passage; slave = the controller.
interface airlock_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             arrive_req;
    logic             depart_req;
    logic             passage;
    logic             arrive_gnt;
    logic             depart_gnt;
    logic             done;
    logic             inner_open;
    logic             outer_open;
    logic             pump_press;
    logic             pump_evac;
    logic             pressurized;
    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic             timeout;

    modport master (
        output arrive_req, depart_req, passage,
        input  arrive_gnt, depart_gnt, done, inner_open, outer_open,
               pump_press, pump_evac, pressurized, state, count, timeout
    );

    modport slave (
        input  arrive_req, depart_req, passage,
        output arrive_gnt, depart_gnt, done, inner_open, outer_open,
               pump_press, pump_evac, pressurized, state, count, timeout
    );
endinterface

// File: rtl/airlock_ctrl.sv
// Airlock sequencer: round-robin arrive/depart arbitration, door and pump sequencing with timed phases.
// Optional door-open watchdog enabled by defining DOOR_TIMEOUT_EN (adds the DOOR_TIMEOUT parameter).
module airlock_ctrl #(
    parameter int PRESS_CYCLES   = 8,
    parameter int DEPRESS_CYCLES = 8,
    parameter int CNT_W          = 4
`ifdef DOOR_TIMEOUT_EN
    ,
    parameter int DOOR_TIMEOUT   = 64
`endif
) (
    input logic          Clock,
    input logic          Reset,
    airlock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE_P     = 3'd0,
        IDLE_D     = 3'd1,
        INNER_OPEN = 3'd2,
        DEPRESS    = 3'd3,
        OUTER_OPEN = 3'd4,
        PRESS      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPRESS_LOAD = CNT_W'(DEPRESS_CYCLES - 1);

    state_t           stateQ, stateNext;
    logic [CNT_W-1:0] countQ, countNext;
    logic             dirQ, dirNext;
    logic             lastDirQ, lastDirNext;
    logic             arriveGntQ, arriveGntNext;
    logic             departGntQ, departGntNext;
    logic             doneQ, doneNext;
    logic             grantOut;
    logic             grantIn;

`ifdef DOOR_TIMEOUT_EN
    localparam int              WD_W    = $clog2(DOOR_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DOOR_TIMEOUT - 1);

    logic [WD_W-1:0] wdogQ, wdogNext;
    logic            timeoutQ, timeoutNext;
`endif

    // On a tie the direction opposite to the last grant wins
    assign grantOut = bus.depart_req && (!bus.arrive_req || !lastDirQ);
    assign grantIn  = bus.arrive_req && !grantOut;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ     <= IDLE_P;
            countQ     <= '0;
            dirQ       <= 1'b0;
            lastDirQ   <= 1'b0;
            arriveGntQ <= 1'b0;
            departGntQ <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateNext;
            countQ     <= countNext;
            dirQ       <= dirNext;
            lastDirQ   <= lastDirNext;
            arriveGntQ <= arriveGntNext;
            departGntQ <= departGntNext;
            doneQ      <= doneNext;
        end
    end

`ifdef DOOR_TIMEOUT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wdogQ    <= '0;
            timeoutQ <= 1'b0;
        end else begin
            wdogQ    <= wdogNext;
            timeoutQ <= timeoutNext;
        end
    end
`endif

    always_comb begin
        stateNext     = stateQ;
        countNext     = '0;
        dirNext       = dirQ;
        lastDirNext   = lastDirQ;
        arriveGntNext = 1'b0;
        departGntNext = 1'b0;
        doneNext      = 1'b0;
`ifdef DOOR_TIMEOUT_EN
        wdogNext      = '0;
        timeoutNext   = 1'b0;
`endif
        case (stateQ)
            IDLE_P, IDLE_D: begin
                if (grantOut) begin
                    departGntNext = 1'b1;
                    dirNext       = 1'b1;
                    lastDirNext   = 1'b1;
                    if (stateQ == IDLE_P) begin
                        stateNext = INNER_OPEN;
                    end else begin
                        stateNext = PRESS;
                        countNext = PRESS_LOAD;
                    end
                end else if (grantIn) begin
                    arriveGntNext = 1'b1;
                    dirNext       = 1'b0;
                    lastDirNext   = 1'b0;
                    if (stateQ == IDLE_P) begin
                        stateNext = DEPRESS;
                        countNext = DEPRESS_LOAD;
                    end else begin
                        stateNext = OUTER_OPEN;
                    end
                end
            end
            INNER_OPEN: begin
                if (bus.passage) begin
                    if (dirQ) begin
                        stateNext = DEPRESS;
                        countNext = DEPRESS_LOAD;
                    end else begin
                        stateNext = IDLE_P;
                        doneNext  = 1'b1;
                    end
                end
`ifdef DOOR_TIMEOUT_EN
                else if (wdogQ == WD_LAST) begin
                    stateNext   = IDLE_P;
                    timeoutNext = 1'b1;
                end else begin
                    wdogNext = wdogQ + 1'b1;
                end
`endif
            end
            OUTER_OPEN: begin
                if (bus.passage) begin
                    if (!dirQ) begin
                        stateNext = PRESS;
                        countNext = PRESS_LOAD;
                    end else begin
                        stateNext = IDLE_D;
                        doneNext  = 1'b1;
                    end
                end
`ifdef DOOR_TIMEOUT_EN
                else if (wdogQ == WD_LAST) begin
                    stateNext   = IDLE_D;
                    timeoutNext = 1'b1;
                end else begin
                    wdogNext = wdogQ + 1'b1;
                end
`endif
            end
            PRESS: begin
                if (countQ == '0) stateNext = INNER_OPEN;
                else              countNext = countQ - 1'b1;
            end
            DEPRESS: begin
                if (countQ == '0) stateNext = OUTER_OPEN;
                else              countNext = countQ - 1'b1;
            end
            default: stateNext = IDLE_P;
        endcase
    end

    // Everything below is decoded from registered state only
    assign bus.inner_open  = (stateQ == INNER_OPEN);
    assign bus.outer_open  = (stateQ == OUTER_OPEN);
    assign bus.pump_press  = (stateQ == PRESS);
    assign bus.pump_evac   = (stateQ == DEPRESS);
    assign bus.pressurized = (stateQ == IDLE_P) || (stateQ == INNER_OPEN);
    assign bus.state       = stateQ;
    assign bus.count       = countQ;
    assign bus.arrive_gnt  = arriveGntQ;
    assign bus.depart_gnt  = departGntQ;
    assign bus.done        = doneQ;
`ifdef DOOR_TIMEOUT_EN
    assign bus.timeout     = timeoutQ;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule
